// File: rtl/mem_readback_streamer_pkg.sv
// mem_readback_streamer_pkg: shared sizes, software-visible region offsets and FSM state encoding
package mem_readback_streamer_pkg;
  localparam int NUM_BYTES_DEF = 102;
  localparam int ADDR_W_DEF    = 8;
  localparam int REGION_HDR    = 0;
  localparam int REGION_A      = 5;
  localparam int REGION_B      = 37;
  localparam int REGION_TAIL   = 101;
  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FIN} state_t;
endpackage

// File: rtl/mem_readback_streamer_flat_byte_select.sv
// flat_byte_select: combinational NUM_BYTES:1 byte mux from a flat bus (byte j at j*8+:8); out-of-range index gives 0
// ports: i_bus flat image, i_idx byte index, o_byte selected byte
module flat_byte_select #(
  parameter int NUM_BYTES = 102,
  parameter int IDX_W     = 8
) (
  input  logic [NUM_BYTES*8-1:0] i_bus,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [7:0]             o_byte
);
  always_comb begin
    o_byte = '0;
    for (int j = 0; j < NUM_BYTES; j++)
      if (i_idx == IDX_W'(j)) o_byte = i_bus[j*8+:8];
  end
endmodule

// File: rtl/mem_readback_streamer.sv
// mem_readback_streamer: streams a window of a flat byte memory out on a valid/ready byte stream
// ports: clk, reset (sync, active-high); start/base_addr/length request; all_data_in memory image;
//        tx_data/tx_valid/tx_ready/tx_last stream; busy, done (1-cycle pulse), err (range error, held)
// option: define STREAM_CHECKSUM_EN to append an XOR checksum beat carrying tx_last
module mem_readback_streamer
  import mem_readback_streamer_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      length,
  input  logic [NUM_BYTES*8-1:0] all_data_in,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   tx_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_rem;
  logic [7:0]        r_data;
  logic              r_valid, r_last, r_busy, r_done, r_err;
  logic [ADDR_W:0]   w_end;
  logic              w_range_err;
  logic [ADDR_W-1:0] w_sel_idx;
  logic [7:0]        w_byte;
`ifdef STREAM_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_ck;
`endif
  // extra bit so base+length cannot wrap before the bound check
  assign w_end       = {1'b0, base_addr} + {1'b0, length};
  assign w_range_err = w_end > (ADDR_W+1)'(NUM_BYTES);
  // IDLE fetches the first byte; STREAM prefetches the next one for the same-edge reload
  assign w_sel_idx   = (r_state == ST_IDLE) ? base_addr : r_idx + ADDR_W'(1);
  flat_byte_select #(.NUM_BYTES(NUM_BYTES), .IDX_W(ADDR_W)) u_sel (
    .i_bus (all_data_in),
    .i_idx (w_sel_idx),
    .o_byte(w_byte)
  );
  assign tx_data  = r_data;
  assign tx_valid = r_valid;
  assign tx_last  = r_last;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef STREAM_CHECKSUM_EN
      r_csum  <= '0;
      r_ck    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_err <= 1'b0;
          r_idx <= base_addr;
          r_rem <= length;
`ifdef STREAM_CHECKSUM_EN
          r_csum <= '0;
          r_ck   <= 1'b0;
`endif
          if (w_range_err) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else if (length == '0) begin
`ifdef STREAM_CHECKSUM_EN
            r_state <= ST_STREAM;
            r_busy  <= 1'b1;
            r_data  <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b1;
            r_ck    <= 1'b1;
`else
            r_done  <= 1'b1;
            r_state <= ST_FIN;
`endif
          end else begin
            r_state <= ST_STREAM;
            r_busy  <= 1'b1;
            r_data  <= w_byte;
            r_valid <= 1'b1;
`ifdef STREAM_CHECKSUM_EN
            r_last  <= 1'b0;
`else
            r_last  <= length == ADDR_W'(1);
`endif
          end
        end
        ST_STREAM: if (r_valid && tx_ready) begin
`ifdef STREAM_CHECKSUM_EN
          if (r_ck) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else if (r_rem == ADDR_W'(1)) begin
            r_data <= r_csum ^ r_data;
            r_last <= 1'b1;
            r_ck   <= 1'b1;
          end else begin
            r_csum <= r_csum ^ r_data;
            r_idx  <= r_idx + ADDR_W'(1);
            r_rem  <= r_rem - ADDR_W'(1);
            r_data <= w_byte;
          end
`else
          if (r_rem == ADDR_W'(1)) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_idx  <= r_idx + ADDR_W'(1);
            r_rem  <= r_rem - ADDR_W'(1);
            r_data <= w_byte;
            r_last <= r_rem == ADDR_W'(2);
          end
`endif
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_readback_streamer.sv
// tb_mem_readback_streamer: table-driven self-checking bench for mem_readback_streamer
module tb_mem_readback_streamer;
`ifdef STREAM_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int NB = 102;
  logic          clk = 1'b0;
  logic          reset, start, tx_ready;
  logic [7:0]    base_addr, length;
  logic [NB*8-1:0] mem;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_last, busy, done, err;
  int            n_cmp = 0;
  int            n_bad = 0;
  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    logic [7:0] pat;
    bit         err;
    int         n;
    logic [7:0] first;
    bit         poke;
  } vec_t;
  vec_t tv[10];
  mem_readback_streamer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .all_data_in(mem), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_xfer(input vec_t v);
    int ntot, k, done_cyc;
    logic [7:0] x, exp_b, hold_d;
    bit hold, any_busy;
    ntot = v.n + ((CK && !v.err) ? 1 : 0);
    x = '0; k = 0; done_cyc = -1; hold = 0; any_busy = 0; hold_d = '0;
    @(negedge clk);
    base_addr = v.base; length = v.len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", 32'(tx_valid), 32'(ntot > 0));
    for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (v.poke && cyc == 1) begin
        start = 1'b1; base_addr = 8'd50; length = 8'd1;
      end else start = 1'b0;
      tx_ready = v.pat[cyc%8];
      if (hold) chk("stall_hold", {tx_valid, tx_data}, {1'b1, hold_d});
      hold = tx_valid && !tx_ready;
      hold_d = tx_data;
      any_busy |= busy;
      if (tx_valid && tx_ready) begin
        exp_b = (k < v.n) ? v.first + 8'(k) : x;
        chk("beat_data", tx_data, exp_b);
        chk("beat_last", 32'(tx_last), 32'(k == ntot - 1));
        if (k < v.n) x ^= exp_b;
        k++;
      end
      if (done) done_cyc = cyc;
    end
    chk("beat_count", k, ntot);
    chk("done_seen", 32'(done_cyc >= 0), 1);
    chk("err", 32'(err), 32'(v.err));
    chk("busy_seen", 32'(any_busy), 32'(ntot > 0));
    if (v.pat == 8'hFF) chk("done_cycle", done_cyc, ntot);
    @(negedge clk);
    chk("done_pulse_end", {done, busy}, 0);
    tx_ready = 1'b0; start = 1'b0;
  endtask
  initial begin
    bit saw_done;
    for (int j = 0; j < NB; j++) mem[j*8+:8] = 8'(j + 1);
    tv[0] = '{8'd5,   8'd3,   8'hFF, 1'b0, 3,   8'h06, 1'b0};
    tv[1] = '{8'd5,   8'd3,   8'hF9, 1'b0, 3,   8'h06, 1'b0};
    tv[2] = '{8'd100, 8'd2,   8'hFF, 1'b0, 2,   8'h65, 1'b0};
    tv[3] = '{8'd100, 8'd3,   8'hFF, 1'b1, 0,   8'h00, 1'b0};
    tv[4] = '{8'd0,   8'd0,   8'hFF, 1'b0, 0,   8'h00, 1'b0};
    tv[5] = '{8'd0,   8'd4,   8'hFF, 1'b0, 4,   8'h01, 1'b1};
    tv[6] = '{8'd101, 8'd1,   8'hFF, 1'b0, 1,   8'h66, 1'b0};
    tv[7] = '{8'd0,   8'd102, 8'hFF, 1'b0, 102, 8'h01, 1'b0};
    tv[8] = '{8'd255, 8'd255, 8'hFF, 1'b1, 0,   8'h00, 1'b0};
    tv[9] = '{8'd3,   8'd5,   8'h55, 1'b0, 5,   8'h04, 1'b0};
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0; base_addr = '0; length = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {tx_data, tx_valid, tx_last, busy, done, err}, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) do_xfer(tv[i]);
    @(negedge clk);
    base_addr = 8'd0; length = 8'd10; start = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_beat0", {tx_valid, tx_data}, {1'b1, 8'h01});
    @(negedge clk);
    chk("rst_beat1", {tx_valid, tx_data}, {1'b1, 8'h02});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {tx_data, tx_valid, tx_last, busy, done, err}, 0);
    reset = 1'b0; tx_ready = 1'b0; saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      saw_done |= done;
    end
    chk("no_done_after_reset", 32'(saw_done), 0);
    do_xfer('{8'd0, 8'd3, 8'hFF, 1'b0, 3, 8'h01, 1'b0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
